// File: rtl/scr1_accel_pkg.sv
// Shared types and constants for the SCR1 vector multiply-accumulate accelerator:
// data-memory bus types, register map, CTRL bit positions and FSM states.
package scr1_accel_pkg;

   localparam int unsigned SCR1_DMEM_AWIDTH = 32;
   localparam int unsigned SCR1_DMEM_DWIDTH = 32;

   typedef enum logic {
      SCR1_MEM_CMD_RD = 1'b0,
      SCR1_MEM_CMD_WR = 1'b1
   } type_scr1_mem_cmd_e;

   typedef enum logic [1:0] {
      SCR1_MEM_WIDTH_BYTE  = 2'b00,
      SCR1_MEM_WIDTH_HWORD = 2'b01,
      SCR1_MEM_WIDTH_WORD  = 2'b10,
      SCR1_MEM_WIDTH_ERROR = 2'b11
   } type_scr1_mem_width_e;

   typedef enum logic [1:0] {
      SCR1_MEM_RESP_NOTRDY = 2'b00,
      SCR1_MEM_RESP_RDY_OK = 2'b01,
      SCR1_MEM_RESP_RDY_ER = 2'b10
   } type_scr1_mem_resp_e;

   // Default geometry: four 8-bit lanes packed in one 32-bit word
   localparam int unsigned VMAC_LANES_DEF = 4;
   localparam int unsigned VMAC_EW_DEF    = 8;

   // Register offsets, decoded from addr[4:2]
   localparam logic [2:0] VMAC_OFS_CTRL  = 3'd0;
   localparam logic [2:0] VMAC_OFS_COUNT = 3'd1;
   localparam logic [2:0] VMAC_OFS_A     = 3'd2;
   localparam logic [2:0] VMAC_OFS_B     = 3'd3;
   localparam logic [2:0] VMAC_OFS_C     = 3'd4;
   localparam logic [2:0] VMAC_OFS_ACC   = 3'd5;

   // CTRL bit positions
   localparam int unsigned VMAC_CTRL_GO       = 0;
   localparam int unsigned VMAC_CTRL_MODE     = 1;
   localparam int unsigned VMAC_CTRL_ACC_KEEP = 2;
   localparam int unsigned VMAC_CTRL_BUSY     = 30;
   localparam int unsigned VMAC_CTRL_DONE     = 31;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } vmac_state_e;

   // Sub-word stores land as the low byte/hword copied across the whole word
   function automatic logic [31:0] vmac_replicate(input type_scr1_mem_width_e width,
                                                  input logic [31:0]           data);
      logic [31:0] res;
      case (width)
         SCR1_MEM_WIDTH_BYTE:  res = {4{data[7:0]}};
         SCR1_MEM_WIDTH_HWORD: res = {2{data[15:0]}};
         default:              res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/scr1_accel_vmac_if.sv
// Core data-memory port of the accelerator; the core side is the master.
interface scr1_accel_vmac_if;
   import scr1_accel_pkg::*;

   logic                        dmem_req;
   type_scr1_mem_cmd_e          dmem_cmd;
   type_scr1_mem_width_e        dmem_width;
   logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
   logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata;
   logic                        dmem_req_ack;
   logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata;
   type_scr1_mem_resp_e         dmem_resp;

   modport master (
      output dmem_req,
      output dmem_cmd,
      output dmem_width,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_req_ack,
      input  dmem_rdata,
      input  dmem_resp
   );

   modport slave (
      input  dmem_req,
      input  dmem_cmd,
      input  dmem_width,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_req_ack,
      output dmem_rdata,
      output dmem_resp
   );

endinterface

// File: rtl/scr1_accel_lane_mul.sv
// Combinational unsigned EW x EW -> 2*EW lane multiplier.
module scr1_accel_lane_mul #(
   parameter int unsigned EW = 8
) (
   input  logic [EW-1:0]   a_i,
   input  logic [EW-1:0]   b_i,
   output logic [2*EW-1:0] p_o
);

   // Operands widened first so the product is computed at full width
   always_comb begin
      p_o = {{EW{1'b0}}, a_i} * {{EW{1'b0}}, b_i};
   end

endmodule

// File: rtl/scr1_accel_vmac.sv
// Memory-mapped vector multiply / dot-product accelerator. One lane is
// processed per cycle through a single shared multiplier.
module scr1_accel_vmac
   import scr1_accel_pkg::*;
#(
   parameter int unsigned LANES = VMAC_LANES_DEF,
   parameter int unsigned EW    = VMAC_EW_DEF
) (
   input logic              clk,
   input logic              rst_n,
   scr1_accel_vmac_if.slave dmem
);

   localparam int unsigned CntW = 3;

   // Bus decode
   logic        wr_req;
   logic        rd_req;
   logic [2:0]  ofs;
   logic [31:0] wdata_rep;
   logic        go_accept;

   // Architectural state
   vmac_state_e         state_q, state_d;
   logic [CntW-1:0]     count_q, count_d;
   logic [31:0]         a_q, a_d;
   logic [31:0]         b_q, b_d;
   logic [31:0]         c_q, c_d;
   logic [31:0]         acc_q, acc_d;
   logic                mode_q, mode_d;
   logic                keep_q, keep_d;
   logic                go_q, go_d;

   // Response path
   type_scr1_mem_resp_e resp_q, resp_d;
   logic [2:0]          rd_sel_q, rd_sel_d;
   logic [1:0]          rd_shift_q, rd_shift_d;
   logic [31:0]         rd_word;
   logic [31:0]         ctrl_rd;

   // Lane datapath
   logic [EW-1:0]       a_lane;
   logic [EW-1:0]       b_lane;
   logic [2*EW-1:0]     prod;

   logic                unused_addr;

   assign unused_addr = ^dmem.dmem_addr[SCR1_DMEM_AWIDTH-1:5];

   // Decode the incoming request; GO is refused while a run is in flight
   always_comb begin
      wr_req    = dmem.dmem_req && (dmem.dmem_cmd == SCR1_MEM_CMD_WR);
      rd_req    = dmem.dmem_req && (dmem.dmem_cmd == SCR1_MEM_CMD_RD);
      ofs       = dmem.dmem_addr[4:2];
      wdata_rep = vmac_replicate(dmem.dmem_width, dmem.dmem_wdata);
      go_accept = wr_req && (ofs == VMAC_OFS_CTRL) && wdata_rep[VMAC_CTRL_GO]
                  && (state_q != StRun);
   end

   // Select the operand elements of the lane addressed by COUNT
   always_comb begin
      a_lane = '0;
      b_lane = '0;
      for (int i = 0; i < LANES; i++) begin
         if (count_q == CntW'(i)) begin
            a_lane = a_q[i*EW +: EW];
            b_lane = b_q[i*EW +: EW];
         end
      end
   end

   scr1_accel_lane_mul #(
      .EW (EW)
   ) u_lane_mul (
      .a_i (a_lane),
      .b_i (b_lane),
      .p_o (prod)
   );

   // Next-state: FSM, operand writes and per-lane result accumulation
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      acc_d   = acc_q;
      mode_d  = mode_q;
      keep_d  = keep_q;
      go_d    = 1'b0;

      // Operands are frozen for the whole run
      if (wr_req && (state_q != StRun)) begin
         if (ofs == VMAC_OFS_A) a_d = wdata_rep;
         if (ofs == VMAC_OFS_B) b_d = wdata_rep;
      end

      case (state_q)
         StIdle, StDone: begin
            if (go_accept) begin
               state_d = StRun;
               count_d = '0;
               c_d     = '0;
               mode_d  = wdata_rep[VMAC_CTRL_MODE];
               keep_d  = wdata_rep[VMAC_CTRL_ACC_KEEP];
               go_d    = 1'b1;
               if (!wdata_rep[VMAC_CTRL_ACC_KEEP]) acc_d = '0;
            end
         end
         StRun: begin
            count_d = count_q + CntW'(1);
            if (mode_q) begin
               acc_d = acc_q + 32'(prod);
            end else begin
               for (int i = 0; i < LANES; i++) begin
                  if (count_q == CntW'(i)) c_d[i*EW +: EW] = prod[EW-1:0];
               end
            end
            // COUNT reaches LANES on the same edge that enters DONE
            if (count_q == CntW'(LANES - 1)) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   // Response status and the read selector latched with each read request
   always_comb begin
      resp_d     = dmem.dmem_req ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_NOTRDY;
      rd_sel_d   = rd_sel_q;
      rd_shift_d = rd_shift_q;
      if (rd_req) begin
         rd_sel_d   = ofs;
         rd_shift_d = dmem.dmem_addr[1:0];
      end
   end

   // State update with synchronous active-low reset; reset aborts any run
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         count_q    <= '0;
         a_q        <= '0;
         b_q        <= '0;
         c_q        <= '0;
         acc_q      <= '0;
         mode_q     <= 1'b0;
         keep_q     <= 1'b0;
         go_q       <= 1'b0;
         resp_q     <= SCR1_MEM_RESP_NOTRDY;
         rd_sel_q   <= '0;
         rd_shift_q <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         a_q        <= a_d;
         b_q        <= b_d;
         c_q        <= c_d;
         acc_q      <= acc_d;
         mode_q     <= mode_d;
         keep_q     <= keep_d;
         go_q       <= go_d;
         resp_q     <= resp_d;
         rd_sel_q   <= rd_sel_d;
         rd_shift_q <= rd_shift_d;
      end
   end

   // Read mux over the latched selector; the shift aligns sub-word reads
   always_comb begin
      ctrl_rd                     = '0;
      ctrl_rd[VMAC_CTRL_DONE]     = (state_q == StDone);
      ctrl_rd[VMAC_CTRL_BUSY]     = (state_q == StRun);
      ctrl_rd[VMAC_CTRL_ACC_KEEP] = keep_q;
      ctrl_rd[VMAC_CTRL_MODE]     = mode_q;
      ctrl_rd[VMAC_CTRL_GO]       = go_q;

      case (rd_sel_q)
         VMAC_OFS_CTRL:  rd_word = ctrl_rd;
         VMAC_OFS_COUNT: rd_word = 32'(count_q);
         VMAC_OFS_A:     rd_word = a_q;
         VMAC_OFS_B:     rd_word = b_q;
         VMAC_OFS_C:     rd_word = c_q;
         VMAC_OFS_ACC:   rd_word = acc_q;
         default:        rd_word = '0;
      endcase
   end

   assign dmem.dmem_req_ack = 1'b1;
   assign dmem.dmem_rdata   = rd_word >> {rd_shift_q, 3'b000};
   assign dmem.dmem_resp    = resp_q;

endmodule

// File: tb/tb_scr1_accel_vmac.sv
// Self-checking bench for scr1_accel_vmac: directed and randomized runs
// compared against a lane-by-lane arithmetic reference model.
module tb_scr1_accel_vmac;
   import scr1_accel_pkg::*;

   localparam int unsigned LANES = 4;
   localparam int unsigned EW    = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   scr1_accel_vmac_if dmem_if ();

   scr1_accel_vmac #(
      .LANES (LANES),
      .EW    (EW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .dmem  (dmem_if)
   );

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic [31:0] m_a, m_b, m_c, m_acc;
   logic        m_mode, m_keep, m_done;

   function automatic logic [31:0] model_repl(input type_scr1_mem_width_e w,
                                              input logic [31:0] d);
      logic [31:0] r;
      if (w == SCR1_MEM_WIDTH_BYTE)       r = 32'(d[7:0]) * 32'h0101_0101;
      else if (w == SCR1_MEM_WIDTH_HWORD) r = 32'(d[15:0]) * 32'h0001_0001;
      else                                r = d;
      return r;
   endfunction

   function automatic void model_go(input logic mode, input logic keep);
      longint unsigned emask, ea, eb, p;
      emask = (longint'(1) << EW) - 1;
      m_c   = '0;
      if (!keep) m_acc = '0;
      for (int i = 0; i < LANES; i++) begin
         ea = (longint'(m_a) >> (EW * i)) & emask;
         eb = (longint'(m_b) >> (EW * i)) & emask;
         p  = ea * eb;
         if (mode) m_acc = 32'((longint'(m_acc) + p) % (longint'(1) << 32));
         else      m_c   = m_c | 32'((p & emask) << (EW * i));
      end
      m_mode = mode;
      m_keep = keep;
   endfunction

   function automatic logic [31:0] ctrl_word(input logic done, input logic busy,
                                             input logic keep, input logic mode,
                                             input logic go);
      logic [31:0] w;
      w = '0;
      w[31] = done;
      w[30] = busy;
      w[2]  = keep;
      w[1]  = mode;
      w[0]  = go;
      return w;
   endfunction

   // Bus tasks: called at a negedge, return at the next negedge
   task automatic bus_wr(input logic [4:0] addr, input logic [31:0] data,
                         input type_scr1_mem_width_e w);
      dmem_if.dmem_req   = 1'b1;
      dmem_if.dmem_cmd   = SCR1_MEM_CMD_WR;
      dmem_if.dmem_addr  = {27'd0, addr};
      dmem_if.dmem_wdata = data;
      dmem_if.dmem_width = w;
      @(negedge clk);
      dmem_if.dmem_req   = 1'b0;
   endtask

   task automatic bus_rd(input logic [4:0] addr, input type_scr1_mem_width_e w,
                         output logic [31:0] d, output type_scr1_mem_resp_e r);
      dmem_if.dmem_req   = 1'b1;
      dmem_if.dmem_cmd   = SCR1_MEM_CMD_RD;
      dmem_if.dmem_addr  = {27'd0, addr};
      dmem_if.dmem_wdata = '0;
      dmem_if.dmem_width = w;
      @(negedge clk);
      d = dmem_if.dmem_rdata;
      r = dmem_if.dmem_resp;
      dmem_if.dmem_req   = 1'b0;
   endtask

   function automatic logic [4:0] reg_addr(input logic [2:0] o);
      return {o, 2'b00};
   endfunction

   task automatic model_reset();
      m_a = '0; m_b = '0; m_c = '0; m_acc = '0;
      m_mode = 1'b0; m_keep = 1'b0; m_done = 1'b0;
   endtask

   // Full run: status before GO, GO pulse, per-cycle BUSY/DONE, then results
   task automatic do_run(input logic mode, input logic keep, input string tag);
      logic [31:0]         d, exp;
      type_scr1_mem_resp_e r;
      bus_rd(reg_addr(VMAC_OFS_CTRL), SCR1_MEM_WIDTH_WORD, d, r);
      exp = ctrl_word(m_done, 1'b0, m_keep, m_mode, 1'b0);
      total++;
      if (d !== exp) begin
         bad++;
         $display("FAIL %s pre_ctrl got=%h exp=%h", tag, d, exp);
      end
      bus_wr(reg_addr(VMAC_OFS_CTRL), {29'd0, keep, mode, 1'b1}, SCR1_MEM_WIDTH_WORD);
      model_go(mode, keep);
      exp = ctrl_word(1'b0, 1'b1, keep, mode, 1'b1);
      total++;
      if (dmem_if.dmem_rdata !== exp) begin
         bad++;
         $display("FAIL %s go_pulse got=%h exp=%h", tag, dmem_if.dmem_rdata, exp);
      end
      for (int j = 2; j <= LANES + 2; j++) begin
         bus_rd(reg_addr(VMAC_OFS_CTRL), SCR1_MEM_WIDTH_WORD, d, r);
         exp = ctrl_word(j >= LANES + 1, j < LANES + 1, keep, mode, 1'b0);
         total++;
         if (d !== exp || r !== SCR1_MEM_RESP_RDY_OK) begin
            bad++;
            $display("FAIL %s ctrl_T+%0d got=%h/%0d exp=%h/RDY_OK", tag, j, d, r, exp);
         end
      end
      m_done = 1'b1;
      bus_rd(reg_addr(VMAC_OFS_C), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== m_c) begin
         bad++;
         $display("FAIL %s c got=%h exp=%h", tag, d, m_c);
      end
      bus_rd(reg_addr(VMAC_OFS_ACC), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== m_acc) begin
         bad++;
         $display("FAIL %s acc got=%h exp=%h", tag, d, m_acc);
      end
      bus_rd(reg_addr(VMAC_OFS_COUNT), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== 32'(LANES)) begin
         bad++;
         $display("FAIL %s count got=%h exp=%h", tag, d, 32'(LANES));
      end
   endtask

   task automatic load_ab(input logic [31:0] a, input logic [31:0] b);
      bus_wr(reg_addr(VMAC_OFS_A), a, SCR1_MEM_WIDTH_WORD);
      bus_wr(reg_addr(VMAC_OFS_B), b, SCR1_MEM_WIDTH_WORD);
      m_a = a;
      m_b = b;
   endtask

   task automatic check_all_zero(input string tag);
      logic [31:0]         d;
      type_scr1_mem_resp_e r;
      total++;
      if (dmem_if.dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
         bad++;
         $display("FAIL %s resp_idle got=%0d exp=NOTRDY", tag, dmem_if.dmem_resp);
      end
      for (int o = 0; o < 8; o++) begin
         bus_rd(reg_addr(3'(o)), SCR1_MEM_WIDTH_WORD, d, r);
         total++;
         if (d !== 32'd0 || r !== SCR1_MEM_RESP_RDY_OK) begin
            bad++;
            $display("FAIL %s reg%0d got=%h/%0d exp=0/RDY_OK", tag, o, d, r);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_all_zero("reset");
   endtask

   task automatic test_directed();
      logic [31:0]         d;
      type_scr1_mem_resp_e r;
      load_ab(32'h0403_0201, 32'h0505_0505);
      do_run(1'b0, 1'b0, "mode0");
      total++;
      if (m_c !== 32'h140F_0A05 || m_acc !== 32'd0) begin
         bad++;
         $display("FAIL model_mode0 c=%h acc=%h exp=140f0a05/0", m_c, m_acc);
      end
      do_run(1'b1, 1'b0, "mode1");
      bus_rd(reg_addr(VMAC_OFS_ACC), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== 32'h0000_0032) begin
         bad++;
         $display("FAIL dot_acc got=%h exp=00000032", d);
      end
      do_run(1'b1, 1'b1, "mode1_keep");
      bus_rd(reg_addr(VMAC_OFS_ACC), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== 32'h0000_0064) begin
         bad++;
         $display("FAIL dot_keep got=%h exp=00000064", d);
      end
      load_ab(32'h0000_0010, 32'h0000_0010);
      do_run(1'b0, 1'b0, "trunc");
      bus_rd(reg_addr(VMAC_OFS_C), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL trunc_c got=%h exp=00000000", d);
      end
      do_run(1'b1, 1'b0, "wide_acc");
      bus_rd(reg_addr(VMAC_OFS_ACC), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== 32'h0000_0100) begin
         bad++;
         $display("FAIL wide_acc got=%h exp=00000100", d);
      end
   endtask

   task automatic test_random();
      logic [31:0]          d, da, db;
      type_scr1_mem_resp_e  r;
      type_scr1_mem_width_e wa, wb;
      logic                 mode, keep;
      for (int n = 0; n < 16; n++) begin
         da = $urandom;
         db = $urandom;
         wa = type_scr1_mem_width_e'($urandom_range(0, 2));
         wb = type_scr1_mem_width_e'($urandom_range(0, 2));
         bus_wr(reg_addr(VMAC_OFS_A), da, wa);
         bus_wr(reg_addr(VMAC_OFS_B), db, wb);
         m_a = model_repl(wa, da);
         m_b = model_repl(wb, db);
         bus_rd(reg_addr(VMAC_OFS_A), SCR1_MEM_WIDTH_WORD, d, r);
         total++;
         if (d !== m_a) begin
            bad++;
            $display("FAIL rand%0d a_repl got=%h exp=%h", n, d, m_a);
         end
         mode = 1'($urandom);
         keep = 1'($urandom);
         do_run(mode, keep, $sformatf("rand%0d", n));
         // Read-only and unmapped offsets must swallow writes
         bus_wr(reg_addr(VMAC_OFS_C), $urandom, SCR1_MEM_WIDTH_WORD);
         bus_wr(reg_addr(VMAC_OFS_ACC), $urandom, SCR1_MEM_WIDTH_WORD);
         bus_wr(reg_addr(3'd6), $urandom, SCR1_MEM_WIDTH_WORD);
         bus_rd(reg_addr(VMAC_OFS_C), SCR1_MEM_WIDTH_WORD, d, r);
         total++;
         if (d !== m_c) begin
            bad++;
            $display("FAIL rand%0d c_ro got=%h exp=%h", n, d, m_c);
         end
         bus_rd(reg_addr(VMAC_OFS_ACC), SCR1_MEM_WIDTH_WORD, d, r);
         total++;
         if (d !== m_acc) begin
            bad++;
            $display("FAIL rand%0d acc_ro got=%h exp=%h", n, d, m_acc);
         end
         bus_rd(reg_addr(3'd6), SCR1_MEM_WIDTH_WORD, d, r);
         total++;
         if (d !== 32'd0) begin
            bad++;
            $display("FAIL rand%0d unmapped got=%h exp=0", n, d);
         end
      end
   endtask

   task automatic test_ignore_in_run();
      logic [31:0]         d, exp;
      type_scr1_mem_resp_e r;
      load_ab(32'h0403_0201, 32'h0505_0505);
      bus_rd(reg_addr(VMAC_OFS_CTRL), SCR1_MEM_WIDTH_WORD, d, r);
      bus_wr(reg_addr(VMAC_OFS_CTRL), 32'h0000_0001, SCR1_MEM_WIDTH_WORD); // GO at T
      model_go(1'b0, 1'b0);
      @(negedge clk);                                                       // T+1 idle
      bus_wr(reg_addr(VMAC_OFS_A), 32'hFFFF_FFFF, SCR1_MEM_WIDTH_WORD);    // T+2
      bus_wr(reg_addr(VMAC_OFS_CTRL), 32'h0000_0003, SCR1_MEM_WIDTH_WORD); // T+3
      bus_rd(reg_addr(VMAC_OFS_CTRL), SCR1_MEM_WIDTH_WORD, d, r);          // sampled T+5
      m_done = 1'b1;
      exp = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (d !== exp) begin
         bad++;
         $display("FAIL ignore ctrl_T+5 got=%h exp=%h", d, exp);
      end
      bus_rd(reg_addr(VMAC_OFS_A), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== m_a) begin
         bad++;
         $display("FAIL ignore a got=%h exp=%h", d, m_a);
      end
      bus_rd(reg_addr(VMAC_OFS_C), SCR1_MEM_WIDTH_WORD, d, r);
      total++;
      if (d !== m_c || d !== 32'h140F_0A05) begin
         bad++;
         $display("FAIL ignore c got=%h exp=%h", d, m_c);
      end
   endtask

   task automatic test_subword_read();
      logic [31:0]         d, exp;
      type_scr1_mem_resp_e r;
      load_ab(32'h0403_0201, 32'h0505_0505);
      do_run(1'b0, 1'b0, "sub_setup");
      bus_rd(5'h11, SCR1_MEM_WIDTH_BYTE, d, r);
      total++;
      if (d !== 32'h0014_0F0A || r !== SCR1_MEM_RESP_RDY_OK) begin
         bad++;
         $display("FAIL byte_read got=%h/%0d exp=00140f0a/RDY_OK", d, r);
      end
      @(negedge clk);
      total++;
      if (dmem_if.dmem_resp !== SCR1_MEM_RESP_NOTRDY) begin
         bad++;
         $display("FAIL resp_notrdy got=%0d exp=NOTRDY", dmem_if.dmem_resp);
      end
      for (int k = 0; k < 4; k++) begin
         bus_rd({VMAC_OFS_A, 2'(k)}, SCR1_MEM_WIDTH_BYTE, d, r);
         exp = m_a >> (8 * k);
         total++;
         if (d !== exp) begin
            bad++;
            $display("FAIL shift_a%0d got=%h exp=%h", k, d, exp);
         end
      end
   endtask

   task automatic test_reset_in_run();
      load_ab(32'h0403_0201, 32'h0505_0505);
      bus_wr(reg_addr(VMAC_OFS_CTRL), 32'h0000_0003, SCR1_MEM_WIDTH_WORD); // GO at T
      @(negedge clk);                                                       // T+1
      rst_n = 1'b0;                                                         // sampled at T+2
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      check_all_zero("reset_in_run");
   endtask

   initial begin
      dmem_if.dmem_req   = 1'b0;
      dmem_if.dmem_cmd   = SCR1_MEM_CMD_RD;
      dmem_if.dmem_width = SCR1_MEM_WIDTH_WORD;
      dmem_if.dmem_addr  = '0;
      dmem_if.dmem_wdata = '0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_directed();
      test_ignore_in_run();
      test_subword_read();
      test_random();
      test_reset_in_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scr1_accel_vmac.md
SCR1_ACCEL_VMAC -- requirements
Module: scr1_accel_vmac

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning element lanes per operand word; legal range 1..4 with LANES*EW <= 32.
REQ-002 SHALL have parameter EW, default 8, meaning element width in bits; legal values 8 or 16.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port dmem_req  input  1  core data request.
REQ-006 SHALL have port dmem_cmd  input  type_scr1_mem_cmd_e  read or write.
REQ-007 SHALL have port dmem_width  input  type_scr1_mem_width_e  byte, hword or word.
REQ-008 SHALL have port dmem_addr  input  SCR1_DMEM_AWIDTH  address; only bits [4:0] are decoded.
REQ-009 SHALL have port dmem_wdata  input  SCR1_DMEM_DWIDTH  write data.
REQ-010 SHALL have port dmem_req_ack  output  1  request accepted; constant 1.
REQ-011 SHALL have port dmem_rdata  output  SCR1_DMEM_DWIDTH  read data.
REQ-012 SHALL have port dmem_resp  output  type_scr1_mem_resp_e  response status.

Function
REQ-013 Register map by addr[4:2]: 0 CTRL, 1 COUNT, 2 A, 3 B, 4 C (read-only), 5 ACC (read-only); all other offsets read 0 and ignore writes.
REQ-014 CTRL write: bit0 GO, bit1 MODE (0 = elementwise multiply, 1 = dot product), bit2 ACC_KEEP; CTRL read: bit31 DONE, bit30 BUSY, bits2:1 latched MODE/ACC_KEEP, bit0 = 1 exactly in the cycle after an accepted GO.
REQ-015 Byte/hword writes SHALL replicate the low byte/hword of dmem_wdata across the word before the register update.
REQ-016 dmem_resp SHALL be RDY_OK in the cycle after any cycle with dmem_req = 1 and NOTRDY otherwise; the module never stalls.
REQ-017 Read data SHALL be the selected register shifted right by 8*addr[1:0], with addr[1:0] latched on the read request.
REQ-018 FSM states IDLE, RUN, DONE; IDLE/DONE -> RUN on a CTRL write with GO=1; RUN -> DONE when COUNT reaches LANES; no other transitions.
REQ-019 On GO: COUNT <= 0; C <= 0; ACC <= 0 unless ACC_KEEP=1; MODE and ACC_KEEP latched.
REQ-020 In RUN, one lane per cycle, lane index = COUNT: p = A[lane] * B[lane] as unsigned 2*EW bits; COUNT increments by 1.
REQ-021 MODE 0: C[lane] <= p truncated to low EW bits; ACC unchanged.
REQ-022 MODE 1: ACC <= ACC + zero-extended p, modulo 2^32; C unchanged.
REQ-023 Latency: GO accepted at cycle T; BUSY=1 from T+1; lane i processed in cycle T+1+i; DONE=1 and BUSY=0 from T+1+LANES.
REQ-024 A GO write while in RUN, and writes to A, B or CTRL while in RUN, SHALL be ignored; reads are always served.
REQ-025 COUNT SHALL hold at LANES in DONE; DONE SHALL clear only on the next accepted GO.
REQ-026 When LANES*EW < 32, C bits above LANES*EW read 0, and the unused A/B bits are stored but not used.

Reset
REQ-027 With rst_n = 0 at a clock edge: FSM = IDLE; A, B, C, ACC, COUNT, MODE, ACC_KEEP, DONE, BUSY = 0; dmem_resp = NOTRDY. Reset in RUN SHALL abort with no partial result retained.
REQ-028 The latched read shift SHALL reset to 0.

Structure
REQ-029 Package scr1_accel_pkg SHALL hold the register offsets, the CTRL bit positions, the FSM state enum and the default LANES/EW values.
REQ-030 The lane multiplier SHALL be sub-module scr1_accel_lane_mul (EW x EW -> 2*EW, combinational); everything else in scr1_accel_vmac.

Verification
REQ-031 MODE0, LANES=4, EW=8, A=0x04030201, B=0x05050505, GO -> DONE at T+5, C=0x140F0A05, COUNT=4, ACC=0.
REQ-032 MODE1, same A and B -> ACC=0x00000032; then GO with ACC_KEEP=1 -> ACC=0x00000064.
REQ-033 MODE0, A=0x00000010, B=0x00000010 -> C lane0 = 0x00 (truncated); MODE1 with the same operands -> ACC=0x00000100.
REQ-034 GO, then at T+2 write A=0xFFFFFFFF and a second GO -> both ignored; result as for the original A; DONE at T+5.
REQ-035 rst_n=0 at T+2 of a run -> next cycle all registers read 0, BUSY=0, DONE=0.
REQ-036 With C=0x140F0A05, byte read at address offset 0x11 -> dmem_rdata=0x00140F0A, resp RDY_OK one cycle later.
